// File: rtl/mux_arbiter.sv
// Two-requester burst arbiter driving a 2:1 data mux.
// A grant is held for a burst that ends on last, on reaching MAX_BURST
// accepted beats, or when the owner drops its request. Round-robin
// fairness comes from a one-bit priority pointer that names the
// requester which did not receive the most recent grant.
module mux_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             valid0,
  input  logic             valid1,
  input  logic             last0,
  input  logic             last1,
  input  logic             out_ready,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  // Count value at which the next accepted beat closes the burst.
  localparam logic [3:0] LAST_COUNT = 4'(MAX_BURST - 1);

  state_t     state_r;
  state_t     state_n;
  state_t     arb_s;
  logic [3:0] count_r;
  logic [3:0] count_n;
  logic       prio_r;
  logic       prio_n;
  logic       sel_r;
  logic       sel_n;
  logic       gnt0_r;
  logic       gnt1_r;
  logic       busy_r;
  logic       beat_s;
  logic       release_s;
  logic       new_grant_s;

  // Both requesting -> preferred one; single requester -> it; none -> IDLE.
  function automatic state_t arbitrate(input logic r0, input logic r1, input logic p);
    state_t res;
    if (r0 && r1) begin
      res = p ? GNT1 : GNT0;
    end else if (r0) begin
      res = GNT0;
    end else if (r1) begin
      res = GNT1;
    end else begin
      res = IDLE;
    end
    return res;
  endfunction

  // Beat and release detection for the current owner.
  always_comb begin
    beat_s    = 1'b0;
    release_s = 1'b0;
    arb_s     = arbitrate(req0, req1, prio_r);
    case (state_r)
      GNT0: begin
        beat_s    = valid0 & out_ready;
        release_s = ~req0 | (beat_s & (last0 | (count_r == LAST_COUNT)));
      end
      GNT1: begin
        beat_s    = valid1 & out_ready;
        release_s = ~req1 | (beat_s & (last1 | (count_r == LAST_COUNT)));
      end
      default: begin
        beat_s    = 1'b0;
        release_s = 1'b0;
      end
    endcase
  end

  // Next-state, counter, priority and select computation.
  always_comb begin
    state_n     = IDLE;
    count_n     = count_r;
    prio_n      = prio_r;
    sel_n       = sel_r;
    new_grant_s = 1'b0;
    case (state_r)
      IDLE: begin
        state_n     = arb_s;
        new_grant_s = (arb_s != IDLE);
      end
      GNT0, GNT1: begin
        if (release_s) begin
          // Hand-over happens on this edge; no idle cycle in between.
          state_n     = arb_s;
          new_grant_s = (arb_s != IDLE);
        end else begin
          state_n     = state_r;
          new_grant_s = 1'b0;
        end
      end
      default: begin
        // Unreachable encodings fall back to IDLE.
        state_n     = IDLE;
        new_grant_s = 1'b0;
      end
    endcase

    if (new_grant_s) begin
      // Every grant (including a re-grant) starts a fresh burst and
      // points priority at the requester that lost this round.
      count_n = 4'd0;
      prio_n  = (state_n == GNT0) ? 1'b1 : 1'b0;
      sel_n   = (state_n == GNT1) ? 1'b1 : 1'b0;
    end else if (state_n == IDLE) begin
      count_n = 4'd0;
    end else if (beat_s) begin
      count_n = count_r + 4'd1;
    end else begin
      count_n = count_r;
    end
  end

  // State, counter and registered outputs; reset clears grants at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      count_r <= 4'd0;
      prio_r  <= 1'b0;
      sel_r   <= 1'b0;
      gnt0_r  <= 1'b0;
      gnt1_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      count_r <= count_n;
      prio_r  <= prio_n;
      sel_r   <= sel_n;
      gnt0_r  <= (state_n == GNT0);
      gnt1_r  <= (state_n == GNT1);
      busy_r  <= (state_n == GNT0) || (state_n == GNT1);
    end
  end

  assign gnt0      = gnt0_r;
  assign gnt1      = gnt1_r;
  assign busy      = busy_r;
  assign sel       = sel_r;
  assign out       = sel_r ? in1 : in0;
  assign out_valid = (gnt0_r & valid0) | (gnt1_r & valid1);

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, sets the data width of in0, in1 and out.
REQ-002 Parameter MAX_BURST, default 4, sets the maximum beats per grant; legal range is 1..15.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req0, req1  input  1 each  requester k asks for ownership of the mux.
REQ-006 in0, in1  input  WIDTH each  requester data.
REQ-007 valid0, valid1  input  1 each  requester k data beat is valid.
REQ-008 last0, last1  input  1 each  marks the final beat of requester k's burst.
REQ-009 out_ready  input  1  downstream accepts a beat this cycle.
REQ-010 gnt0, gnt1  output  1 each  registered grant; the two grants are one-hot or zero.
REQ-011 sel  output  1  registered mux select: 0 selects in0, 1 selects in1.
REQ-012 out  output  WIDTH  combinational value: in1 when sel=1, otherwise in0.
REQ-013 out_valid  output  1  combinational: (gnt0 & valid0) | (gnt1 & valid1).
REQ-014 busy  output  1  high whenever gnt0 or gnt1 is high.

Function
REQ-015 The FSM SHALL have three states: IDLE (no grant), GNT0, GNT1; gnt0=1 only in GNT0 and gnt1=1 only in GNT1.
REQ-016 A beat SHALL occur on a cycle where state=GNTk, valid_k=1 and out_ready=1.
REQ-017 A 1-bit priority pointer prio SHALL name the preferred requester; it is set to the non-granted requester on every grant.
REQ-018 Arbitration function: if both req high -> grant prio; else if exactly one req high -> grant that requester; else -> IDLE.
REQ-019 From IDLE, the arbitration function SHALL be evaluated each cycle; the grant is visible the cycle after req is sampled (1-cycle latency).
REQ-020 A 4-bit beat counter SHALL clear on entry to any GNT state and increment on each beat.
REQ-021 In GNTk, release occurs on a beat with last_k=1 or with counter=MAX_BURST-1, or on any cycle with req_k=0.
REQ-022 On release, the next state SHALL be chosen by the arbitration function using the updated prio, with no idle cycle between grants.
REQ-023 If requester k is still the sole requester on release, it is re-granted (a new burst) and the counter restarts at 0.
REQ-024 Without release, GNTk SHALL hold; valid_k low or out_ready low stalls the burst without consuming a count.
REQ-025 sel SHALL update on the same edge as the grant (0 for GNT0, 1 for GNT1) and hold its last value in IDLE.
REQ-026 gnt0 and gnt1 SHALL never be high in the same cycle; a grant switch is 1->0 and 0->1 on the same edge.
REQ-027 Changes on a non-granted requester's valid, last or in SHALL NOT affect out_valid.
REQ-028 Illegal state encodings SHALL return to IDLE on the next clock.

Reset
REQ-029 While rst=1: state=IDLE, gnt0=gnt1=0, busy=0, sel=0, prio=0 (requester 0 preferred), counter=0.
REQ-030 Assertion of rst mid-burst SHALL clear grants immediately without waiting for a clock; an in-flight burst is abandoned.
REQ-031 After rst deasserts, arbitration SHALL resume on the first rising clk edge.

Verification
REQ-032 Reset, then req0=req1=1 on the same cycle -> gnt0=1, sel=0 one cycle later; prio=1.
REQ-033 Both requesting, MAX_BURST=4, valid and ready always high, last never asserted -> 4 beats from in0, then gnt1 on the next edge with no idle cycle, then 4 beats from in1, alternating.
REQ-034 Only req1 high, burst of 2 with last1 on beat 2 -> gnt1 for exactly 2 beats, then re-grant to 1 if req1 is still high, else IDLE with sel held at 1.
REQ-035 out_ready toggles 1,0,1,0 during a GNT0 burst -> counter advances only on ready cycles; release follows the 4th accepted beat.
REQ-036 rst pulsed mid-burst between clock edges -> gnt0, gnt1 and busy go to 0 asynchronously; after release, req1 alone -> gnt1 on the next edge.
